output_port_allocator: RTL and testbench

OUTPUT_PORT_ALLOCATOR -- requirements
Module: output_port_allocator

---
 rtl/output_port_allocator_pkg.sv | 14 +
 rtl/output_port_allocator_rr_arbiter.sv | 57 +++++
 rtl/output_port_allocator.sv | 126 ++++++++++++
 tb/tb_output_port_allocator.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/output_port_allocator_pkg.sv
// Shared NoC definitions for the output port allocator: FSM state encoding and
// watchdog / packet counter widths.
package output_port_allocator_pkg;

    typedef enum logic [0:0] {
        StIdle   = 1'b0,
        StLocked = 1'b1
    } opa_state_e;

    // Wide enough for the largest supported TIMEOUT (255).
    localparam int unsigned StallCntW = 8;
    localparam int unsigned PktCntW   = 16;

endpackage

// File: rtl/output_port_allocator_rr_arbiter.sv
// Round-robin arbiter using a masked/raw priority scheme; the pointer moves past
// the index supplied on update_i, so the caller decides when a grant is final.
module output_port_allocator_rr_arbiter #(
    parameter int unsigned N    = 5,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            arst,
    input  logic [N-1:0]    req_i,
    input  logic            update_i,
    input  logic [IdxW-1:0] upd_idx_i,
    output logic [N-1:0]    grant_o,
    output logic [IdxW-1:0] idx_o
);

    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [N-1:0]    mask;
    logic [N-1:0]    masked;
    logic [N-1:0]    pick;
    logic            found;

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < N; i++) begin
            mask[i] = (i >= 32'(ptr_q));
        end
        masked = req_i & mask;
        // Fall back to the unmasked vector when nothing sits at or above ptr.
        pick    = (|masked) ? masked : req_i;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (pick[i] && !found) begin
                grant_o[i] = 1'b1;
                idx_o      = IdxW'(i);
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (update_i) begin
            ptr_d = (upd_idx_i == IdxW'(N - 1)) ? '0 : upd_idx_i + IdxW'(1);
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/output_port_allocator.sv
// Wormhole output port allocator: arbitrates head flits round-robin, then holds
// the output for the winning packet until its tail flit transfers.
module output_port_allocator
    import output_port_allocator_pkg::*;
#(
    parameter int unsigned N_IN    = 5,
    parameter int unsigned TIMEOUT = 16,
    localparam int unsigned IdxW   = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic               clk,
    input  logic               arst,
    input  logic [N_IN-1:0]    req_i,
    input  logic [N_IN-1:0]    head_i,
    input  logic [N_IN-1:0]    tail_i,
    input  logic               out_ready_i,
    output logic [N_IN-1:0]    grant_o,
    output logic               out_valid_o,
    output logic               locked_o,
    output logic [IdxW-1:0]    owner_o,
    output logic               stall_err_o,
    output logic [PktCntW-1:0] pkt_cnt_o
);

    localparam logic [StallCntW-1:0] StallMax = StallCntW'(TIMEOUT);

    opa_state_e           state_q, state_d;
    logic [IdxW-1:0]      owner_q, owner_d;
    logic [StallCntW-1:0] stall_q, stall_d;
    logic                 err_q, err_d;
    logic [PktCntW-1:0]   pkt_q, pkt_d;

    logic [N_IN-1:0] eligible;
    logic [N_IN-1:0] arb_grant;
    logic [IdxW-1:0] arb_idx;
    logic [IdxW-1:0] sel_idx;
    logic            xfer;
    logic            done;

    assign eligible = req_i & head_i;

    output_port_allocator_rr_arbiter #(
        .N (N_IN)
    ) u_rr_arbiter (
        .clk       (clk),
        .arst      (arst),
        .req_i     (eligible),
        .update_i  (done),
        .upd_idx_i (sel_idx),
        .grant_o   (arb_grant),
        .idx_o     (arb_idx)
    );

    // Grant is combinational; reset gates it so nothing leaks out during reset.
    always_comb begin
        grant_o = '0;
        if (arst) begin
            if (state_q == StIdle) begin
                grant_o = arb_grant;
            end else begin
                grant_o[owner_q] = req_i[owner_q];
            end
        end
    end

    assign sel_idx     = (state_q == StIdle) ? arb_idx : owner_q;
    assign out_valid_o = |(grant_o & req_i);
    assign xfer        = out_valid_o & out_ready_i;
    assign done        = xfer & tail_i[sel_idx];

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        pkt_d   = pkt_q;
        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    owner_d = arb_idx;
                    if (!tail_i[arb_idx]) begin
                        state_d = StLocked;
                    end
                end
            end
            StLocked: begin
                if (done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (done) begin
            pkt_d = pkt_q + PktCntW'(1);
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (xfer || (state_d == StIdle)) begin
            stall_d = '0;
        end else if (stall_q != StallMax) begin
            stall_d = stall_q + StallCntW'(1);
        end
        err_d = err_q | (stall_d == StallMax);
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q <= StIdle;
            owner_q <= '0;
            stall_q <= '0;
            err_q   <= 1'b0;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            stall_q <= stall_d;
            err_q   <= err_d;
            pkt_q   <= pkt_d;
        end
    end

    assign locked_o    = (state_q == StLocked);
    assign owner_o     = owner_q;
    assign stall_err_o = err_q;
    assign pkt_cnt_o   = pkt_q;

endmodule

// File: tb/tb_output_port_allocator.sv
// Directed self-checking bench for output_port_allocator (N_IN=5, TIMEOUT=8).
module tb_output_port_allocator;

    logic        clk;
    logic        arst;
    logic [4:0]  req;
    logic [4:0]  head;
    logic [4:0]  tail;
    logic        rdy;
    logic [4:0]  grant;
    logic        out_valid;
    logic        locked;
    logic [2:0]  owner;
    logic        err;
    logic [15:0] pkt;

    int checks = 0;
    int errors = 0;

    output_port_allocator #(
        .N_IN    (5),
        .TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .arst        (arst),
        .req_i       (req),
        .head_i      (head),
        .tail_i      (tail),
        .out_ready_i (rdy),
        .grant_o     (grant),
        .out_valid_o (out_valid),
        .locked_o    (locked),
        .owner_o     (owner),
        .stall_err_o (err),
        .pkt_cnt_o   (pkt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] r, input logic [4:0] h, input logic [4:0] t,
                         input logic rd);
        req  = r;
        head = h;
        tail = t;
        rdy  = rd;
    endtask

    initial begin
        logic [4:0] e;
        // Reset with a live head request: grant must stay low.
        arst = 1'b0;
        drive(5'b00001, 5'b00001, 5'b00001, 1'b1);
        #2;
        chk("rst_grant", grant, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_owner", owner, 0);
        chk("rst_err", err, 0);
        chk("rst_pkt", pkt, 0);
        cyc();
        chk("rst_hold_grant", grant, 0);
        chk("rst_hold_pkt", pkt, 0);
        drive(5'b00000, 5'b00000, 5'b00000, 1'b1);
        arst = 1'b1;

        // Single-flit packets on ports 1 and 2.
        drive(5'b00110, 5'b00110, 5'b00110, 1'b1);
        #1 chk("single_c1_grant", grant, 5'b00010);
        cyc();
        chk("single_c1_pkt", pkt, 1);
        chk("single_c1_owner", owner, 1);
        drive(5'b00100, 5'b00100, 5'b00100, 1'b1);
        #1 chk("single_c2_grant", grant, 5'b00100);
        cyc();
        chk("single_c2_pkt", pkt, 2);
        chk("single_c2_locked", locked, 0);
        chk("single_c2_owner", owner, 2);

        // Request without head is ignored in IDLE.
        drive(5'b00100, 5'b00000, 5'b00000, 1'b1);
        #1 chk("nohead_grant", grant, 0);
        chk("nohead_valid", out_valid, 0);
        cyc();
        chk("nohead_locked", locked, 0);
        chk("nohead_owner", owner, 2);
        chk("nohead_pkt", pkt, 2);

        // 3-flit packet on port 0 (ptr=3 wraps to 0) with port 2 waiting.
        drive(5'b00101, 5'b00101, 5'b00100, 1'b1);
        #1 chk("multi_head_grant", grant, 5'b00001);
        cyc();
        chk("multi_head_locked", locked, 1);
        chk("multi_head_owner", owner, 0);
        drive(5'b00101, 5'b00101, 5'b00100, 1'b1);
        #1 chk("multi_body_headagain_grant", grant, 5'b00001);
        cyc();
        chk("multi_body_locked", locked, 1);
        chk("multi_body_pkt", pkt, 2);
        drive(5'b00101, 5'b00100, 5'b00101, 1'b1);
        #1 chk("multi_tail_grant", grant, 5'b00001);
        cyc();
        chk("multi_tail_locked", locked, 0);
        chk("multi_tail_pkt", pkt, 3);
        drive(5'b00100, 5'b00100, 5'b00100, 1'b1);
        #1 chk("after_tail_grant", grant, 5'b00100);
        cyc();
        chk("after_tail_pkt", pkt, 4);

        // Fresh reset so the round-robin sweep starts at port 0.
        drive(5'b00000, 5'b00000, 5'b00000, 1'b1);
        arst = 1'b0;
        #1 chk("rst2_pkt", pkt, 0);
        arst = 1'b1;
        drive(5'b11111, 5'b11111, 5'b11111, 1'b1);
        for (int k = 0; k < 6; k++) begin
            e = 5'b00001 << (k % 5);
            #1 chk($sformatf("rr_grant_%0d", k), grant, e);
            cyc();
        end
        chk("rr_pkt", pkt, 6);

        // Lock port 3 (ptr=1), then stall 10 cycles.
        drive(5'b01000, 5'b01000, 5'b00000, 1'b1);
        #1 chk("stall_head_grant", grant, 5'b01000);
        cyc();
        chk("stall_locked", locked, 1);
        chk("stall_owner", owner, 3);
        drive(5'b01000, 5'b00000, 5'b00000, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            #1 if (k == 1) chk("stall_valid", out_valid, 1);
            cyc();
            if (k == 7) chk("stall_err_7", err, 0);
            if (k == 8) chk("stall_err_8", err, 1);
        end
        chk("stall_keeps_lock", locked, 1);
        drive(5'b01000, 5'b00000, 5'b01000, 1'b1);
        #1 chk("stall_tail_grant", grant, 5'b01000);
        cyc();
        chk("stall_tail_locked", locked, 0);
        chk("stall_tail_pkt", pkt, 7);
        chk("stall_err_sticky", err, 1);
        drive(5'b00000, 5'b00000, 5'b00000, 1'b1);
        cyc();
        chk("stall_err_sticky2", err, 1);

        // Reset in the middle of a packet on port 1.
        drive(5'b00010, 5'b00010, 5'b00000, 1'b1);
        #1 chk("midrst_head_grant", grant, 5'b00010);
        cyc();
        chk("midrst_locked_before", locked, 1);
        chk("midrst_owner_before", owner, 1);
        drive(5'b00010, 5'b00000, 5'b00000, 1'b1);
        #1 arst = 1'b0;
        #1 chk("midrst_locked", locked, 0);
        chk("midrst_grant", grant, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_owner", owner, 0);
        chk("midrst_err", err, 0);
        arst = 1'b1;
        drive(5'b10001, 5'b10001, 5'b10001, 1'b1);
        #1 chk("post_rst_grant", grant, 5'b00001);
        cyc();
        chk("post_rst_pkt", pkt, 1);
        chk("post_rst_owner", owner, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
